// File: rtl/mm_pkg.sv
// Shared defaults and drain FSM encoding for the matrix-multiplier result drain.
package mm_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 16;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        DRAIN_IDLE,
        DRAIN_READ,
        DRAIN_FLUSH
    } drain_state_t;

endpackage

// File: rtl/result_drain_if.sv
// Result RAM read port plus outbound valid/ready word stream.
interface result_drain_if #(
    parameter int DATA_WIDTH = mm_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mm_pkg::ADDR_WIDTH
);

    logic                  rd_enb;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_ready;

    modport master (
        output rd_enb, rd_addr, out_valid, out_data, out_last,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_enb, rd_addr, out_valid, out_data, out_last,
        output rd_data, out_ready
    );

endinterface

// File: rtl/result_fifo.sv
// Small synchronous FIFO; head is read combinationally from storage and occupancy is exported.
module result_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/result_drain.sv
// Walks a result RAM address range after the accelerator finishes and streams each word out.
module result_drain #(
    parameter int DATA_WIDTH = mm_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mm_pkg::ADDR_WIDTH,
    parameter int FIFO_DEPTH = mm_pkg::FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  busyb,
    output logic                  done,
    result_drain_if.master        bus
);

    import mm_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH:0] ONE = 1;

    drain_state_t          state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   issued;
    logic [ADDR_WIDTH:0]   sent;
    logic                  in_flight;

    logic [DATA_WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic                  fifo_wr;
    logic                  fifo_rd;
    logic                  credit_ok;
    logic                  issue;
    logic                  fire;

    // A returning word bypasses the FIFO when it is empty so the first beat lands the cycle data returns.
    always_comb begin
        credit_ok     = (CNT_W'(in_flight) + fifo_count) < CNT_W'(FIFO_DEPTH);
        issue         = (state == DRAIN_READ) && credit_ok;
        bus.rd_enb    = issue;
        bus.rd_addr   = base_q + issued[ADDR_WIDTH-1:0];
        bus.out_valid = !fifo_empty || in_flight;
        bus.out_data  = '0;
        if (!fifo_empty)
            bus.out_data = fifo_head;
        else if (in_flight)
            bus.out_data = bus.rd_data;
        bus.out_last  = bus.out_valid && (sent == count_q - ONE);
        fire          = bus.out_valid && bus.out_ready;
        fifo_rd       = !fifo_empty && bus.out_ready;
        fifo_wr       = in_flight && !(fifo_empty && bus.out_ready);
    end

    result_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (bus.rd_data),
        .rd_en   (fifo_rd),
        .head    (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DRAIN_IDLE;
            base_q    <= '0;
            count_q   <= '0;
            issued    <= '0;
            sent      <= '0;
            in_flight <= 1'b0;
            busyb     <= 1'b1;
            done      <= 1'b0;
        end else begin
            done      <= 1'b0;
            in_flight <= issue;
            if (fire) sent <= sent + ONE;
            case (state)
                DRAIN_IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        count_q <= word_count;
                        issued  <= '0;
                        sent    <= '0;
                        if (word_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= DRAIN_READ;
                            busyb <= 1'b0;
                        end
                    end
                end
                DRAIN_READ: begin
                    if (issue) begin
                        issued <= issued + ONE;
                        if (issued + ONE == count_q) state <= DRAIN_FLUSH;
                    end
                end
                DRAIN_FLUSH: begin
                    if (fire && bus.out_last) begin
                        state <= DRAIN_IDLE;
                        busyb <= 1'b1;
                        done  <= 1'b1;
                    end
                end
                default: state <= DRAIN_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_drain.sv
// Randomised bench for result_drain against a word-count level model of the drain stream.
module tb_result_drain;

    localparam int DW    = 64;
    localparam int AW    = 16;
    localparam int DEPTH = 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic          busyb;
    logic          done;
    logic [31:0]   salt;

    int checks   = 0;
    int failures = 0;

    result_drain_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    result_drain #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busyb      (busyb),
        .done       (done),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ram_word(input logic [15:0] a);
        return {salt, a, ~a};
    endfunction

    // Result RAM: one-cycle registered read.
    always @(posedge clk) begin
        if (bus.rd_enb) bus.rd_data <= ram_word(bus.rd_addr);
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "/rd_enb"},    64'(bus.rd_enb),    64'd0);
        checkOutput({tag, "/rd_addr"},   64'(bus.rd_addr),   64'd0);
        checkOutput({tag, "/out_valid"}, 64'(bus.out_valid), 64'd0);
        checkOutput({tag, "/out_data"},  bus.out_data,       64'd0);
        checkOutput({tag, "/out_last"},  64'(bus.out_last),  64'd0);
        checkOutput({tag, "/busyb"},     64'(busyb),         64'd1);
        checkOutput({tag, "/done"},      64'(done),          64'd0);
    endtask

    // mode: 0 ready always high, 1 ready low in cycles 3..6, 2 random ready.
    // again_at: cycle of an extra start pulse that must be ignored; abort_at: cycle to assert reset.
    task automatic applyStimulus(input logic [15:0] base, input logic [16:0] cnt, input int mode,
                                 input int again_at, input int abort_at, input string name);
        int   m_issued;
        int   m_sent;
        int   done_exp;
        logic exp_enb;
        logic exp_valid;
        logic exp_busyb;
        logic rdy;
        m_issued = 0;
        m_sent   = 0;
        done_exp = (cnt == 0) ? 1 : -1;
        @(negedge clk);
        base_addr     = base;
        word_count    = cnt;
        start         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c < 400; c++) begin
            case (mode)
                1:       rdy = !(c >= 3 && c <= 6);
                2:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = 1'b1;
            endcase
            bus.out_ready = rdy;
            start = (c == again_at);
            if (c == again_at) begin
                base_addr  = base ^ 16'h0F0F;
                word_count = cnt + 17'd3;
            end
            if (c == abort_at) begin
                rst_n = 1'b0;
                #1;
                checkResetValues({name, "/abort"});
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    checkOutput({name, "/no_done"}, 64'(done), 64'd0);
                    checkOutput({name, "/no_valid"}, 64'(bus.out_valid), 64'd0);
                end
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            exp_enb   = (m_issued < int'(cnt)) && ((m_issued - m_sent) < DEPTH);
            exp_valid = (m_issued > m_sent);
            exp_busyb = !(cnt != 0 && (done_exp < 0 || c < done_exp));
            checkOutput($sformatf("%s/c%0d/rd_enb", name, c),    64'(bus.rd_enb),    64'(exp_enb));
            checkOutput($sformatf("%s/c%0d/out_valid", name, c), 64'(bus.out_valid), 64'(exp_valid));
            checkOutput($sformatf("%s/c%0d/busyb", name, c),     64'(busyb),         64'(exp_busyb));
            checkOutput($sformatf("%s/c%0d/done", name, c),      64'(done),          64'(c == done_exp));
            if (exp_enb)
                checkOutput($sformatf("%s/c%0d/rd_addr", name, c), 64'(bus.rd_addr), 64'(16'(base + m_issued)));
            if (exp_valid) begin
                checkOutput($sformatf("%s/c%0d/out_data", name, c), bus.out_data, ram_word(16'(base + m_sent)));
                checkOutput($sformatf("%s/c%0d/out_last", name, c), 64'(bus.out_last),
                            64'(m_sent == int'(cnt) - 1));
            end
            if (exp_enb) m_issued++;
            if (exp_valid && rdy) begin
                if (m_sent == int'(cnt) - 1) done_exp = c + 1;
                m_sent++;
            end
            if (done_exp > 0 && c >= done_exp + 2) begin
                start = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checkOutput({name, "/timeout"}, 64'd1, 64'd0);
    endtask

    initial begin
        logic [15:0] rbase;
        logic [16:0] rcnt;
        rst_n         = 1'b0;
        start         = 1'b0;
        base_addr     = '0;
        word_count    = '0;
        bus.out_ready = 1'b0;
        salt          = $urandom;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(16'h0010, 17'd4, 0, 0, 0, "basic");
        applyStimulus(16'h0010, 17'd4, 1, 0, 0, "stall");
        applyStimulus(16'hFFFE, 17'd4, 0, 0, 0, "wrap");
        applyStimulus(16'h0000, 17'd0, 0, 0, 0, "zero");
        applyStimulus(16'h0100, 17'd8, 0, 0, 3, "abort");
        applyStimulus(16'h0200, 17'd5, 0, 0, 0, "after_abort");
        applyStimulus(16'h0300, 17'd6, 2, 3, 0, "restart_ignored");
        applyStimulus(16'h0400, 17'd1, 1, 0, 0, "single");

        for (int i = 0; i < 10; i++) begin
            rbase = 16'($urandom);
            if (i % 3 == 0) rbase = 16'hFFF0 | 16'($urandom_range(0, 15));
            rcnt = 17'($urandom_range(1, 12));
            applyStimulus(rbase, rcnt, 2, (i % 2 == 1) ? 2 : 0, 0, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
